// File: rtl/score_text_writer_if.sv
// Command and read-port bundle between a command source / glyph renderer and
// the score text writer.
interface score_text_writer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_value;
    logic [3:0]  cmd_row;
    logic [3:0]  cmd_col;
    logic        cmd_lzb;
    logic        busy;
    logic        done;
    logic [3:0]  rd_col;
    logic [3:0]  rd_row;
    logic [5:0]  rd_glyph;

    modport master (
        output cmd_valid, cmd_op, cmd_value, cmd_row, cmd_col, cmd_lzb, rd_col, rd_row,
        input  cmd_ready, busy, done, rd_glyph
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_value, cmd_row, cmd_col, cmd_lzb, rd_col, rd_row,
        output cmd_ready, busy, done, rd_glyph
    );
endinterface

// File: rtl/score_text_writer.sv
// Writes decimal numbers, single glyphs or a full clear into a 16x15 glyph
// buffer; the renderer reads it through a registered, independent read port.
module score_text_writer #(
    parameter int         COLS       = 16,
    parameter int         ROWS       = 15,
    parameter int         NDIGITS    = 5,
    parameter logic [5:0] BLANK_CODE = 6'd63
) (
    input  logic               clk,
    input  logic               reset,
    score_text_writer_if.slave bus
);
    localparam int         DEPTH     = COLS * ROWS;
    localparam int         BCD_W     = 4 * NDIGITS;
    localparam logic [7:0] CONV_LAST = 8'd15;
    localparam logic [7:0] DIG_LAST  = 8'(NDIGITS - 1);
    localparam logic [7:0] CLR_LAST  = 8'(DEPTH - 1);
    localparam logic [4:0] COLS_W    = 5'(COLS);
    localparam logic [3:0] ROWS_W    = 4'(ROWS);

    typedef enum logic [2:0] {
        S_IDLE, S_CONVERT, S_WRITE, S_GLYPH, S_CLEAR
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               clr_cmd_q, clr_cmd_d;
    logic               done_q, done_d;
    logic [15:0]        sh_q, sh_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [3:0]         row_q, row_d, col_q, col_d;
    logic               lzb_q, lzb_d, seen_q, seen_d;

    logic               we;
    logic [7:0]         waddr;
    logic [5:0]         wdata;
    logic [3:0]         digit;
    logic [4:0]         wcol;
    logic               blank;

    logic [5:0]         mem [DEPTH];
    logic [5:0]         rd_glyph_q;
    logic               rd_in;

    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < NDIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_cmd_d = clr_cmd_q;
        done_d    = 1'b0;
        sh_d      = sh_q;
        bcd_d     = bcd_q;
        row_d     = row_q;
        col_d     = col_q;
        lzb_d     = lzb_q;
        seen_d    = seen_q;
        bcd_adj   = dabble_adj(bcd_q);
        digit     = bcd_q[BCD_W-1 -: 4];
        wcol      = {1'b0, col_q} + {2'b00, cnt_q[2:0]};
        blank     = 1'b0;
        we        = 1'b0;
        waddr     = '0;
        wdata     = BLANK_CODE;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    sh_d   = bus.cmd_value;
                    row_d  = bus.cmd_row;
                    col_d  = bus.cmd_col;
                    lzb_d  = bus.cmd_lzb;
                    bcd_d  = '0;
                    seen_d = 1'b0;
                    cnt_d  = '0;
                    unique case (bus.cmd_op)
                        2'd0: state_d = S_CONVERT;
                        2'd1: state_d = S_GLYPH;
                        2'd2: begin
                            state_d   = S_CLEAR;
                            clr_cmd_d = 1'b1;
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            S_CONVERT: begin
                bcd_d = {bcd_adj[BCD_W-2:0], sh_q[15]};
                sh_d  = {sh_q[14:0], 1'b0};
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CONV_LAST) begin
                    state_d = S_WRITE;
                    cnt_d   = '0;
                end
            end
            S_WRITE: begin
                // Digits leave MSB first by shifting the BCD word left a nibble per cycle.
                blank  = lzb_q && !seen_q && (digit == 4'd0) && (cnt_q != DIG_LAST);
                seen_d = seen_q || (digit != 4'd0);
                bcd_d  = {bcd_q[BCD_W-5:0], 4'd0};
                we     = (wcol < COLS_W) && (row_q < ROWS_W);
                waddr  = {row_q, wcol[3:0]};
                wdata  = blank ? BLANK_CODE : {2'b00, digit};
                cnt_d  = cnt_q + 8'd1;
                if (cnt_q == DIG_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_GLYPH: begin
                we      = ({1'b0, col_q} < COLS_W) && (row_q < ROWS_W);
                waddr   = {row_q, col_q};
                wdata   = sh_q[5:0];
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            S_CLEAR: begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = BLANK_CODE;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CLR_LAST) begin
                    state_d   = S_IDLE;
                    done_d    = clr_cmd_q;
                    clr_cmd_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state: reset parks the FSM at the start of the clear sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_CLEAR;
            cnt_q     <= '0;
            clr_cmd_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_cmd_q <= clr_cmd_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        sh_q   <= sh_d;
        bcd_q  <= bcd_d;
        row_q  <= row_d;
        col_q  <= col_d;
        lzb_q  <= lzb_d;
        seen_q <= seen_d;
    end

    always_ff @(posedge clk) begin
        if (we && !reset) mem[waddr] <= wdata;
    end

    // Read-before-write: a same-cycle write to the read cell shows up next read.
    assign rd_in = (bus.rd_row < ROWS_W) && ({1'b0, bus.rd_col} < COLS_W);

    always_ff @(posedge clk) begin
        if (reset)      rd_glyph_q <= BLANK_CODE;
        else if (rd_in) rd_glyph_q <= mem[{bus.rd_row, bus.rd_col}];
        else            rd_glyph_q <= BLANK_CODE;
    end

    assign bus.rd_glyph  = rd_glyph_q;
    assign bus.cmd_ready = !reset && (state_q == S_IDLE);
    assign bus.busy      = reset || (state_q != S_IDLE);
    assign bus.done      = done_q && !reset;
endmodule

// File: tb/tb_score_text_writer.sv
// Directed bench for score_text_writer: reset sweep, number rendering,
// glyph writes, clear, handshake hold-off and mid-command reset.
module tb_score_text_writer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    score_text_writer_if bus();
    score_text_writer dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_cell(input logic [3:0] r, input logic [3:0] c, output logic [5:0] g);
        bus.rd_row = r;
        bus.rd_col = c;
        tick();
        g = bus.rd_glyph;
    endtask

    // Issues one command and returns the cycle (1 = cycle after accept) in which done is seen.
    task automatic issue(input logic [1:0] op, input logic [15:0] val, input logic [3:0] r,
                         input logic [3:0] c, input logic lzb, output int cyc);
        int w = 0;
        while (!bus.cmd_ready && w < 300) begin
            tick();
            w++;
        end
        bus.cmd_op = op; bus.cmd_value = val; bus.cmd_row = r; bus.cmd_col = c;
        bus.cmd_lzb = lzb; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 400) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        int bad_busy = 0, saw_done = 0, bad_cells = 0;
        logic [5:0] g;
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.done !== 1'b0 || bus.rd_glyph !== 6'd63)
            $display("FAIL reset_hold busy=%b ready=%b done=%b glyph=%0d want 1 0 0 63",
                     bus.busy, bus.cmd_ready, bus.done, bus.rd_glyph);
        if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.done !== 1'b0 || bus.rd_glyph !== 6'd63)
            n_bad++;
        reset = 1'b0;
        for (int k = 1; k <= 240; k++) begin
            if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) bad_busy++;
            if (bus.done !== 1'b0) saw_done++;
            tick();
        end
        n_cmp++;
        if (bad_busy != 0) begin n_bad++; $display("FAIL reset_sweep_busy bad_cycles=%0d want 0", bad_busy); end
        n_cmp++;
        if (saw_done != 0) begin n_bad++; $display("FAIL reset_no_done done_cycles=%0d want 0", saw_done); end
        n_cmp++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready_241 ready=%b busy=%b done=%b want 1 0 0", bus.cmd_ready, bus.busy, bus.done);
        end
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 16; c++) begin
                read_cell(4'(r), 4'(c), g);
                if (g !== 6'd63) bad_cells++;
            end
        n_cmp++;
        if (bad_cells != 0) begin n_bad++; $display("FAIL reset_buffer nonblank=%0d want 0", bad_cells); end
        read_cell(4'd15, 4'd3, g);
        n_cmp++;
        if (g !== 6'd63) begin n_bad++; $display("FAIL oob_read got %0d want 63", g); end
    endtask

    task automatic test_number();
        int cyc;
        logic [5:0] g;
        int exp_row[7] = '{63, 63, 1, 2, 3, 4, 63};
        issue(2'd0, 16'd1234, 4'd2, 4'd3, 1'b1, cyc);
        n_cmp++;
        if (cyc != 22) begin n_bad++; $display("FAIL num1234_latency got %0d want 22", cyc); end
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL num1234_ready_at_done got %b want 1", bus.cmd_ready); end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL num1234_done_width got %b want 0", bus.done); end
        for (int i = 0; i < 7; i++) begin
            read_cell(4'd2, 4'(2 + i), g);
            n_cmp++;
            if (g !== 6'(exp_row[i])) begin
                n_bad++;
                $display("FAIL num1234_cell(2,%0d) got %0d want %0d", 2 + i, g, exp_row[i]);
            end
        end
    endtask

    task automatic test_digits();
        int cyc;
        logic [5:0] g;
        int vals[5]  = '{0, 0, 10, 40960, 9};
        int lzbs[5]  = '{1, 0, 1, 1, 0};
        int rows[5]  = '{5, 5, 6, 6, 6};
        int cols[5]  = '{0, 5, 0, 6, 11};
        int exps[5][5] = '{'{63, 63, 63, 63, 0}, '{0, 0, 0, 0, 0}, '{63, 63, 63, 1, 0},
                           '{4, 0, 9, 6, 0}, '{0, 0, 0, 0, 9}};
        for (int t = 0; t < 5; t++) begin
            issue(2'd0, 16'(vals[t]), 4'(rows[t]), 4'(cols[t]), 1'(lzbs[t]), cyc);
            n_cmp++;
            if (cyc != 22) begin n_bad++; $display("FAIL digits%0d_latency got %0d want 22", t, cyc); end
            for (int i = 0; i < 5; i++) begin
                read_cell(4'(rows[t]), 4'(cols[t] + i), g);
                n_cmp++;
                if (g !== 6'(exps[t][i])) begin
                    n_bad++;
                    $display("FAIL digits%0d_cell(%0d,%0d) got %0d want %0d", t, rows[t], cols[t] + i, g, exps[t][i]);
                end
            end
        end
    endtask

    task automatic test_edge_col();
        int cyc;
        logic [5:0] g;
        int cc[6]  = '{13, 14, 15, 0, 1, 2};
        int rr[6]  = '{0, 0, 0, 1, 1, 1};
        int ex[6]  = '{63, 6, 5, 63, 63, 63};
        issue(2'd0, 16'd65535, 4'd0, 4'd14, 1'b0, cyc);
        n_cmp++;
        if (cyc != 22) begin n_bad++; $display("FAIL edge_latency got %0d want 22", cyc); end
        for (int i = 0; i < 6; i++) begin
            read_cell(4'(rr[i]), 4'(cc[i]), g);
            n_cmp++;
            if (g !== 6'(ex[i])) begin
                n_bad++;
                $display("FAIL edge_cell(%0d,%0d) got %0d want %0d", rr[i], cc[i], g, ex[i]);
            end
        end
    endtask

    task automatic test_glyph();
        int cyc;
        logic [5:0] g;
        issue(2'd1, 16'd10, 4'd14, 4'd15, 1'b0, cyc);
        n_cmp++;
        if (cyc != 2) begin n_bad++; $display("FAIL glyph_latency got %0d want 2", cyc); end
        read_cell(4'd14, 4'd15, g);
        n_cmp++;
        if (g !== 6'd10) begin n_bad++; $display("FAIL glyph_cell(14,15) got %0d want 10", g); end
        read_cell(4'd14, 4'd14, g);
        n_cmp++;
        if (g !== 6'd63) begin n_bad++; $display("FAIL glyph_cell(14,14) got %0d want 63", g); end
        issue(2'd1, 16'd33, 4'd15, 4'd0, 1'b0, cyc);
        n_cmp++;
        if (cyc != 2) begin n_bad++; $display("FAIL glyph_oob_latency got %0d want 2", cyc); end
        issue(2'd3, 16'd7, 4'd3, 4'd3, 1'b0, cyc);
        n_cmp++;
        if (cyc != 1) begin n_bad++; $display("FAIL op3_latency got %0d want 1", cyc); end
        read_cell(4'd3, 4'd3, g);
        n_cmp++;
        if (g !== 6'd63) begin n_bad++; $display("FAIL op3_no_write got %0d want 63", g); end
    endtask

    task automatic test_back_to_back();
        int cyc, cyc2, bad_acc = 0;
        logic [5:0] g;
        int ex[7] = '{0, 0, 0, 7, 7, 20, 63};
        int rr[7] = '{7, 7, 7, 7, 7, 8, 8};
        int cc[7] = '{0, 1, 2, 3, 4, 0, 1};
        bus.cmd_op = 2'd0; bus.cmd_value = 16'd77; bus.cmd_row = 4'd7; bus.cmd_col = 4'd0;
        bus.cmd_lzb = 1'b0; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_op = 2'd1; bus.cmd_value = 16'd21; bus.cmd_row = 4'd8; bus.cmd_col = 4'd1;
        cyc = 1;
        while (!bus.done && cyc < 400) begin
            if (bus.cmd_ready !== 1'b0) bad_acc++;
            tick();
            cyc++;
        end
        n_cmp++;
        if (cyc != 22) begin n_bad++; $display("FAIL b2b_first_latency got %0d want 22", cyc); end
        n_cmp++;
        if (bad_acc != 0) begin n_bad++; $display("FAIL b2b_ready_while_busy cycles=%0d want 0", bad_acc); end
        bus.cmd_value = 16'd20; bus.cmd_col = 4'd0;
        tick();
        bus.cmd_valid = 1'b0;
        cyc2 = 1;
        while (!bus.done && cyc2 < 400) begin
            tick();
            cyc2++;
        end
        n_cmp++;
        if (cyc2 != 2) begin n_bad++; $display("FAIL b2b_second_latency got %0d want 2", cyc2); end
        for (int i = 0; i < 7; i++) begin
            read_cell(4'(rr[i]), 4'(cc[i]), g);
            n_cmp++;
            if (g !== 6'(ex[i])) begin
                n_bad++;
                $display("FAIL b2b_cell(%0d,%0d) got %0d want %0d", rr[i], cc[i], g, ex[i]);
            end
        end
    endtask

    task automatic test_clear();
        int cyc, bad_cells = 0;
        logic [5:0] g;
        issue(2'd2, 16'd0, 4'd0, 4'd0, 1'b0, cyc);
        n_cmp++;
        if (cyc != 241) begin n_bad++; $display("FAIL clear_latency got %0d want 241", cyc); end
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 16; c++) begin
                read_cell(4'(r), 4'(c), g);
                if (g !== 6'd63) bad_cells++;
            end
        n_cmp++;
        if (bad_cells != 0) begin n_bad++; $display("FAIL clear_buffer nonblank=%0d want 0", bad_cells); end
    endtask

    task automatic test_reset_mid();
        int bad_busy = 0, saw_done = 0, bad_cells = 0;
        logic [5:0] g;
        bus.cmd_op = 2'd0; bus.cmd_value = 16'd12345; bus.cmd_row = 4'd10; bus.cmd_col = 4'd0;
        bus.cmd_lzb = 1'b0; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        repeat (17) tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_hold busy=%b ready=%b done=%b want 1 0 0", bus.busy, bus.cmd_ready, bus.done);
        end
        reset = 1'b0;
        for (int k = 1; k <= 240; k++) begin
            if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) bad_busy++;
            if (bus.done !== 1'b0) saw_done++;
            tick();
        end
        n_cmp++;
        if (bad_busy != 0) begin n_bad++; $display("FAIL midreset_busy bad_cycles=%0d want 0", bad_busy); end
        n_cmp++;
        if (saw_done != 0) begin n_bad++; $display("FAIL midreset_no_done done_cycles=%0d want 0", saw_done); end
        n_cmp++;
        if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_ready_241 ready=%b done=%b want 1 0", bus.cmd_ready, bus.done);
        end
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 16; c++) begin
                read_cell(4'(r), 4'(c), g);
                if (g !== 6'd63) bad_cells++;
            end
        n_cmp++;
        if (bad_cells != 0) begin n_bad++; $display("FAIL midreset_buffer nonblank=%0d want 0", bad_cells); end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_value = 16'd0;
        bus.cmd_row = 4'd0; bus.cmd_col = 4'd0; bus.cmd_lzb = 1'b0;
        bus.rd_row = 4'd0; bus.rd_col = 4'd0;
        test_reset();
        test_number();
        test_digits();
        test_edge_col();
        test_glyph();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/score_text_writer.md
# score_text_writer

Writer end of the on-screen text path. Accepts commands over a valid/ready handshake: render a 16-bit binary number as decimal glyphs, write one glyph, or clear the screen. Results land in an internal 16-column x 15-row glyph buffer. The glyph renderer reads the buffer through a registered read port indexed by hpos[7:4] / vpos[7:4] and feeds each code to the 5x5 font ROM.

## Interface
- COLS, 16: buffer columns (16-pixel cells).
- ROWS, 15: buffer rows.
- NDIGITS, 5: decimal digits per number; covers 0..65535.
- BLANK_CODE, 6'd63: glyph code the renderer draws as empty. Any code >35 is blank.

- clk  in  1  system clock. All logic on the rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; a command is accepted on an edge where valid&ready.
- cmd_op  in  2  0 = number, 1 = glyph, 2 = clear, 3 = reserved (accepted, no writes, done pulses).
- cmd_value  in  16  number to render (op 0), or glyph code in [5:0] (op 1).
- cmd_row  in  4  target row.
- cmd_col  in  4  target column of the leftmost digit / glyph.
- cmd_lzb  in  1  leading-zero blanking (op 0 only).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on command completion.
- rd_col  in  4  renderer read column.
- rd_row  in  4  renderer read row.
- rd_glyph  out  6  buffer[rd_row][rd_col], registered, 1-cycle latency. Out-of-range address returns BLANK_CODE.

## Operation
- States: IDLE, CONVERT, WRITE, GLYPH, CLEAR.
- IDLE, on accept:
  - op 0 → CONVERT
  - op 1 → GLYPH
  - op 2 → CLEAR
  - op 3 → IDLE, with done next cycle.
- Command fields are latched at accept. Inputs are ignored while busy.
- CONVERT: sequential double-dabble on a 16-bit shift register plus 20-bit BCD register.
  - Each cycle: first add 3 to every BCD nibble >=5, then shift left one bit.
  - Exactly 16 cycles, then → WRITE.
- WRITE: NDIGITS cycles, one buffer write per cycle.
  - Most significant digit first, at (row, col+i) for i = 0..4.
  - Glyph code = digit value 0..9.
  - If cmd_lzb=1: leading zeros are written as BLANK_CODE. The least significant digit is never blanked.
  - Writes with col+i >= COLS or row >= ROWS are suppressed; there is no wrap to the next row. Cycle count is unchanged.
  - After the last cycle → IDLE with done.
- GLYPH: one write of cmd_value[5:0] at (row, col), suppressed if out of range. → IDLE with done.
- CLEAR: COLS*ROWS cycles writing BLANK_CODE in row-major order from (0,0). → IDLE with done.
- Reset:
  - While reset is high: state forced to CLEAR with address 0, cmd_ready=0, busy=1, done=0, rd_glyph=BLANK_CODE.
  - After release, the CLEAR sweep runs (240 cycles). It ends in IDLE with no done pulse.
  - Reset mid-command aborts it. Any partial writes are erased by the sweep.
- Read port: one read per cycle, independent of the write side. On a read and write to the same cell in the same cycle, the read returns the old value.

## Timing
Let edge A be the accept edge.
- op 0:
  - Conversion on edges A+1..A+16.
  - Digit writes on edges A+17..A+21.
  - done and cmd_ready high in the cycle after edge A+21.
  - Next accept possible at edge A+22.
- op 1: write at edge A+1; done in the cycle after it.
- op 2: writes on edges A+1..A+240; done after edge A+240.
- done coincides with the first IDLE cycle; cmd_ready is high in that same cycle.
- rd_glyph updates on the edge after rd_row/rd_col are presented. A write at edge E is visible to a read address presented in the cycle after E.

## Test plan
- Reset held 3 cycles, then released:
  - busy=1 and cmd_ready=0 for 240 cycles; cmd_ready=1 in cycle 241; done never pulses.
  - Sweep of all 240 addresses reads 63.
- op 0, value 1234, lzb=1, row 2, col 3:
  - cells (2,3..7) = 63,1,2,3,4.
  - done exactly 22 cycles after accept; neighbouring cells unchanged.
- op 0, value 0:
  - lzb=1 → 63,63,63,63,0.
  - Same value with lzb=0 → 0,0,0,0,0.
- op 0, value 65535, lzb=0, row 0, col 14:
  - (0,14)=6, (0,15)=5; row 1 untouched.
  - done still at +22.
- op 1, code 10, row 14, col 15 → rd_glyph=10 at that cell.
  - cmd_valid held high while busy: no accept, and the fields of the second command are not latched until cmd_ready=1.
- op 0 accepted, reset pulsed on edge A+18 (during WRITE):
  - 240-cycle clear follows; all cells read 63; no done pulse.
